// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// PWM duty capture: counts high cycles per lane over a 2**DWIDTH-cycle window opened by
// an hsync rising edge, then replays one duty word per lane on the data/valid/start framing.
module pwm_capture #(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8
) (
  input  logic              clkforcounter,
  input  logic              rst,
  input  logic              hsync,
  input  logic [STAGE-1:0]  pwm_in,
  output logic [DWIDTH-1:0] data,
  output logic              valid,
  output logic              start,
  output logic              sat,
  output logic              busy,
  output logic              missed
);

  localparam int IDXW = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam logic [DWIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, OUTPUT} state_t;

  state_t            state, state_nxt;
  logic              hsync_q;
  logic              hs_edge;
  logic [DWIDTH-1:0] cnt [STAGE];
  logic [STAGE-1:0]  sat_bits;
  logic [DWIDTH-1:0] wcnt;
  logic [IDXW-1:0]   idx;
  logic              win_done;
  logic              last_word;

  function automatic logic [DWIDTH-1:0] sat_inc(input logic [DWIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + DWIDTH'(1);
  endfunction

  assign hs_edge   = hsync & ~hsync_q;
  // WINDOW-1 is all ones, so the window ends when the counter is full
  assign win_done  = (wcnt == CNT_MAX);
  assign last_word = (idx == IDXW'(STAGE - 1));

  always_ff @(posedge clkforcounter or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs_edge)   state_nxt = MEASURE;
      MEASURE: if (win_done)  state_nxt = OUTPUT;
      OUTPUT:  if (last_word) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkforcounter or negedge rst) begin
    if (!rst) begin
      hsync_q  <= 1'b0;
      for (int i = 0; i < STAGE; i++) cnt[i] <= '0;
      sat_bits <= '0;
      wcnt     <= '0;
      idx      <= '0;
    end else begin
      hsync_q <= hsync;
      case (state)
        IDLE: begin
          if (hs_edge) begin
            for (int i = 0; i < STAGE; i++) cnt[i] <= '0;
            sat_bits <= '0;
            wcnt     <= '0;
          end
        end
        MEASURE: begin
          for (int i = 0; i < STAGE; i++) begin
            if (pwm_in[i]) begin
              cnt[i] <= sat_inc(cnt[i]);
              if (cnt[i] == CNT_MAX) sat_bits[i] <= 1'b1;
            end
          end
          wcnt <= wcnt + DWIDTH'(1);
          if (win_done) idx <= '0;
        end
        OUTPUT: begin
          idx <= last_word ? '0 : idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered burst outputs; data keeps the last word once the burst ends
  always_ff @(posedge clkforcounter or negedge rst) begin
    if (!rst) begin
      data   <= '0;
      valid  <= 1'b0;
      start  <= 1'b0;
      sat    <= 1'b0;
      busy   <= 1'b0;
      missed <= 1'b0;
    end else begin
      valid  <= (state == OUTPUT);
      start  <= (state == OUTPUT) && (idx == '0);
      sat    <= (state == OUTPUT) && sat_bits[idx];
      if (state == OUTPUT) data <= cnt[idx];
      busy   <= (state != IDLE) || hs_edge;
      missed <= hs_edge && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Bench for pwm_capture: table of lane waveforms with expected duty words fed through a
// scoreboard, plus hand-written busy-hsync and reset-abort sequences.
module tb_pwm_capture;
  localparam int STAGE  = 8;
  localparam int DWIDTH = 8;
  localparam int WINDOW = 1 << DWIDTH;
  localparam int NVEC   = 4;

  logic              clk;
  logic              rst;
  logic              hsync;
  logic [STAGE-1:0]  pwm_in;
  logic [DWIDTH-1:0] data;
  logic              valid, start, sat, busy, missed;

  pwm_capture #(.STAGE(STAGE), .DWIDTH(DWIDTH)) dut (
    .clkforcounter(clk), .rst(rst), .hsync(hsync), .pwm_in(pwm_in),
    .data(data), .valid(valid), .start(start), .sat(sat), .busy(busy), .missed(missed)
  );

  // Lane waveform: high for a samples, low for g, high for b (from window sample 0)
  typedef struct {
    int          a     [STAGE];
    int          g     [STAGE];
    int          b     [STAGE];
    logic [7:0]  exp_d [STAGE];
    logic        exp_s [STAGE];
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       st;
  } exp_t;

  vec_t tab [NVEC];
  exp_t sbq [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t_edge  = 0;
  int   word_n  = 0;
  int   missed_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic lane_hi(input int v, input int i, input int k);
    int a, g, b;
    a = tab[v].a[i]; g = tab[v].g[i]; b = tab[v].b[i];
    return (k < a) || ((k >= a + g) && (k < a + g + b));
  endfunction

  // Scoreboard check of every word the DUT emits
  always @(negedge clk) begin
    if (missed) missed_cnt++;
    if (rst && valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_word", {23'd0, data, sat}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("word", {22'd0, data, sat, start}, {22'd0, e.d, e.s, e.st});
        if (start) begin
          word_n = 0;
          chk("first_word_latency", cyc - t_edge, WINDOW + 1);
        end
        if (word_n == STAGE - 1) chk("last_word_latency", cyc - t_edge, WINDOW + STAGE);
        word_n++;
      end
    end
  end

  task automatic do_capture(input int v, input bit busy_edges);
    int fall;
    int m0;
    m0 = missed_cnt;
    for (int i = 0; i < STAGE; i++) begin
      exp_t e;
      e.d = tab[v].exp_d[i]; e.s = tab[v].exp_s[i]; e.st = (i == 0);
      sbq.push_back(e);
    end
    hsync = 1'b1;
    @(posedge clk); #1;
    t_edge = cyc;
    chk("busy_after_edge", busy, 1);
    for (int k = 0; k < WINDOW; k++) begin
      hsync = busy_edges && (k == 100);
      for (int i = 0; i < STAGE; i++) pwm_in[i] = lane_hi(v, i, k);
      @(posedge clk); #1;
    end
    pwm_in = '0;
    fall = -1;
    for (int j = WINDOW + 1; j <= WINDOW + STAGE + 11; j++) begin
      hsync = busy_edges && (j == WINDOW + 1 || j == WINDOW + STAGE);
      @(posedge clk); #1;
      if (!busy && fall < 0) fall = cyc - t_edge;
    end
    hsync = 1'b0;
    chk("busy_fall_latency", fall, WINDOW + STAGE + 1);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("missed_count", missed_cnt - m0, busy_edges ? 3 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; hsync = 1'b0; pwm_in = '0;

    for (int v = 0; v < NVEC; v++)
      for (int i = 0; i < STAGE; i++) begin
        tab[v].a[i] = 0; tab[v].g[i] = 0; tab[v].b[i] = 0;
        tab[v].exp_d[i] = 8'h00; tab[v].exp_s[i] = 1'b0;
      end
    for (int i = 0; i < STAGE; i++) begin
      tab[0].a[i] = i; tab[0].exp_d[i] = 8'(i);
    end
    tab[1].a[1] = 255; tab[1].exp_d[1] = 8'hFF;
    tab[1].a[2] = 256; tab[1].exp_d[2] = 8'hFF; tab[1].exp_s[2] = 1'b1;
    tab[2].a[3] = 10; tab[2].g[3] = 5; tab[2].b[3] = 20; tab[2].exp_d[3] = 8'h1E;
    tab[3].a[1] = 36;  tab[3].exp_d[1] = 8'h24;
    tab[3].a[2] = 72;  tab[3].exp_d[2] = 8'h48;
    tab[3].a[3] = 108; tab[3].exp_d[3] = 8'h6C;
    tab[3].g[4] = 100; tab[3].b[4] = 50; tab[3].exp_d[4] = 8'h32;
    tab[3].a[5] = 200; tab[3].g[5] = 50; tab[3].b[5] = 6; tab[3].exp_d[5] = 8'hCE;
    tab[3].a[6] = 216; tab[3].exp_d[6] = 8'hD8;
    tab[3].a[7] = 252; tab[3].exp_d[7] = 8'hFC;

    #3;
    chk("reset_data", data, 0);
    chk("reset_valid", valid, 0);
    chk("reset_start", start, 0);
    chk("reset_sat", sat, 0);
    chk("reset_busy", busy, 0);
    chk("reset_missed", missed, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int v = 0; v < NVEC; v++) do_capture(v, 1'b0);

    // hsync edges during MEASURE, OUTPUT and on the return to IDLE are ignored
    do_capture(0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_capture_after_ignored_edge", busy, 0);

    // Reset 50 samples into a window with every lane high
    hsync = 1'b1;
    @(posedge clk); #1;
    hsync = 1'b0;
    pwm_in = '1;
    repeat (50) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("abort_data", data, 0);
    chk("abort_valid", valid, 0);
    chk("abort_start", start, 0);
    chk("abort_sat", sat, 0);
    chk("abort_busy", busy, 0);
    chk("abort_missed", missed, 0);
    pwm_in = '0;
    hsync = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // hsync already high at release acts as the opening edge
    do_capture(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the multi-stage PWM generator: measures the high time of STAGE PWM lanes over a fixed window that opens on a rising edge of hsync.
- Returns one DWIDTH-bit duty word per lane as a serial burst on the data/start framing used by the generator input, so captured words can be looped straight back.
- Sits on the counter clock domain beside the PWM block; used for loopback self-test and for capturing external PWM.

Parameters:
- STAGE, 8, number of PWM lanes / words per burst
- DWIDTH, 8, duty word width; measurement window WINDOW = 2**DWIDTH cycles

Ports:
- clkforcounter  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- hsync  input  1  frame marker; rising edge opens a measurement window
- pwm_in  input  STAGE  PWM lanes; must be synchronous to clkforcounter
- data  output  DWIDTH  captured duty word, lane order 0..STAGE-1
- valid  output  1  high for every cycle data carries a word
- start  output  1  high only with the lane-0 word
- sat  output  1  high with a word whose lane counter saturated
- busy  output  1  high in MEASURE and OUTPUT
- missed  output  1  one-cycle pulse when an hsync rising edge is ignored

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; data=0, valid=0, start=0, sat=0, busy=0, missed=0; all lane counters, sat bits, window counter, lane index and hsync_q cleared.
- Edge detect: hsync_q registers hsync each cycle; edge = hsync & ~hsync_q. A level-high hsync at reset release counts as an edge on the first clock.
- States: IDLE, MEASURE, OUTPUT. All outputs are registered.
- IDLE: on edge -> MEASURE; clear lane counters, sat bits, window counter.
- MEASURE: each edge, for every lane i: if pwm_in[i]=1, cnt[i]+1, holding at 2**DWIDTH-1 and setting sat[i] on an increment attempt at max. Window counter increments; on the edge where it equals WINDOW-1 (exactly WINDOW samples taken, first sample on the edge after the hsync edge) -> OUTPUT, lane index=0.
- Lane counts are total high cycles in the window; multiple pulses on one lane accumulate. A lane high for all WINDOW samples reads 2**DWIDTH-1 with sat=1.
- OUTPUT: STAGE consecutive cycles, one word each: data=cnt[idx], sat=sat[idx], valid=1, start=(idx==0). First word is driven the cycle after the last MEASURE sample. After idx=STAGE-1 -> IDLE; valid, start and sat drop to 0; data holds its last value.
- busy=1 from the cycle after the hsync edge through the last OUTPUT word.
- hsync edge in MEASURE or OUTPUT: ignored (window not restarted) and missed pulses for one cycle. An edge on the same clock as the return to IDLE is also ignored and flagged.
- Reset asserted mid-MEASURE or mid-OUTPUT aborts at once. No partial burst resumes; the next capture needs a new hsync edge after reset release.
- Arithmetic: counters are DWIDTH wide and saturate, never wrap. Window counter is DWIDTH wide and wraps only on exit.

Test Plan:
- Loopback: PWM generator loaded with 00..07, outputs tied to pwm_in, hsync shared -> 8 valid words 0x00..0x07, start with the first word only, sat=0 throughout.
- Extremes: lane0 never high, lane1 high 255 cycles, lane2 high all 256 window cycles -> words 0x00, 0xFF sat=0, 0xFF sat=1.
- Split pulses: lane3 high 10 cycles, low 5, high 20 -> word3=0x1E; other lanes 0.
- Busy hsync: second hsync rising edge 100 cycles into MEASURE, and another during OUTPUT -> missed pulses once per edge; burst timing and values unchanged; busy stays high.
- Reset mid-capture: rst low at window cycle 50 -> all outputs 0 within the same cycle, busy=0. Fresh hsync after release -> correct burst, with no residue from the aborted window.
- Latency: hsync edge at cycle T -> first valid/start at T+WINDOW+1, last word at T+WINDOW+STAGE, busy low at T+WINDOW+STAGE+1.
